// File: rtl/matrizes_pkg.sv
// Shared constants and state encoding for the matrix loader and the downstream multiplier.
package matrizes_pkg;

    localparam int N      = 5;
    localparam int ELEM_W = 8;
    localparam int MAT_W  = N * N * ELEM_W;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // True on the element index that completes an n x n matrix.
    function automatic logic is_last_elem(input logic [CNT_W-1:0] cnt, input int n);
        return (cnt == CNT_W'(n * n - 1));
    endfunction

endpackage

// File: rtl/carregador_matrizes_if.sv
// Element stream in, assembled matrix pair out; master = producer/consumer side, slave = loader.
interface carregador_matrizes_if #(
    parameter int ELEM_W = matrizes_pkg::ELEM_W,
    parameter int MAT_W  = matrizes_pkg::MAT_W,
    parameter int CNT_W  = matrizes_pkg::CNT_W
);
    logic signed [ELEM_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     abort;
    logic [MAT_W-1:0]         A;
    logic [MAT_W-1:0]         B;
    logic                     mat_valid;
    logic                     mat_ready;
    logic [CNT_W-1:0]         elem_cnt;

    modport master (
        output in_data, in_valid, abort, mat_ready,
        input  in_ready, A, B, mat_valid, elem_cnt
    );

    modport slave (
        input  in_data, in_valid, abort, mat_ready,
        output in_ready, A, B, mat_valid, elem_cnt
    );
endinterface

// File: rtl/carregador_matrizes.sv
// Streams row-major elements of A then B into flat registers and holds the pair until
// the multiplier acknowledges it.
module carregador_matrizes #(
    parameter int N      = matrizes_pkg::N,
    parameter int ELEM_W = matrizes_pkg::ELEM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    carregador_matrizes_if.slave  bus
);
    import matrizes_pkg::*;

    localparam int MAT_BITS = N * N * ELEM_W;

    state_t                state_r;
    logic [CNT_W-1:0]      elem_cnt_r;
    logic [MAT_BITS-1:0]   a_r;
    logic [MAT_BITS-1:0]   b_r;
    logic                  mat_valid_r;
    logic                  in_ready_r;
    logic                  take_s;

    assign take_s        = bus.in_valid & in_ready_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.A         = a_r;
    assign bus.B         = b_r;
    assign bus.mat_valid = mat_valid_r;
    assign bus.elem_cnt  = elem_cnt_r;

    // Load sequencer, element write decoder and handshake outputs in one register process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= LOAD_A;
            elem_cnt_r  <= {CNT_W{1'b0}};
            a_r         <= {MAT_BITS{1'b0}};
            b_r         <= {MAT_BITS{1'b0}};
            mat_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (bus.abort) begin
            // Abort wins over any transfer or acknowledge in the same cycle.
            state_r     <= LOAD_A;
            elem_cnt_r  <= {CNT_W{1'b0}};
            a_r         <= {MAT_BITS{1'b0}};
            b_r         <= {MAT_BITS{1'b0}};
            mat_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                LOAD_A, LOAD_B: begin
                    if (take_s) begin
                        for (int e = 0; e < N * N; e++) begin
                            if (elem_cnt_r == CNT_W'(e)) begin
                                if (state_r == LOAD_A) begin
                                    a_r[e*ELEM_W +: ELEM_W] <= bus.in_data;
                                end else begin
                                    b_r[e*ELEM_W +: ELEM_W] <= bus.in_data;
                                end
                            end
                        end
                        if (is_last_elem(elem_cnt_r, N)) begin
                            elem_cnt_r <= {CNT_W{1'b0}};
                            if (state_r == LOAD_A) begin
                                state_r <= LOAD_B;
                            end else begin
                                state_r     <= HOLD;
                                mat_valid_r <= 1'b1;
                                in_ready_r  <= 1'b0;
                            end
                        end else begin
                            elem_cnt_r <= elem_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                HOLD: begin
                    if (bus.mat_ready) begin
                        state_r     <= LOAD_A;
                        mat_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= LOAD_A;
                    elem_cnt_r  <= {CNT_W{1'b0}};
                    mat_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_matrizes.sv
// Directed bench for carregador_matrizes: streams, bubbles, hold, abort, extreme values, async reset.
module tb_carregador_matrizes;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    carregador_matrizes_if bus ();

    carregador_matrizes dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: A=1..25, B=identity; mode 1: all 8'h80; mode 2: A=7e+3, B=255-e
    function automatic logic [7:0] elem_val(input int mode, input int e);
        int j;
        j = e - 25;
        case (mode)
            0: elem_val = (e < 25) ? 8'(e + 1) : (((j / 5) == (j % 5)) ? 8'd1 : 8'd0);
            1: elem_val = 8'h80;
            default: elem_val = (e < 25) ? 8'(e * 7 + 3) : 8'(255 - j);
        endcase
    endfunction

    function automatic logic [199:0] exp_mat(input int mode, input int which);
        logic [199:0] m;
        m = '0;
        for (int e = 0; e < 25; e++) m[e*8 +: 8] = elem_val(mode, e + which * 25);
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input int mode, output logic mv_early);
        mv_early = 1'b0;
        for (int e = 0; e < 50; e++) begin
            bus.in_data  = elem_val(mode, e);
            bus.in_valid = 1'b1;
            if (e == 49) mv_early = bus.mat_valid;
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic release_hold();
        bus.mat_ready = 1'b1;
        step();
        bus.mat_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.abort = 1'b0; bus.mat_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.A !== 200'd0) begin n_fail++; $display("FAIL rst_a: got %h want 0", bus.A); end
        n_checks++; if (bus.B !== 200'd0) begin n_fail++; $display("FAIL rst_b: got %h want 0", bus.B); end
        n_checks++; if (bus.mat_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mat_valid: got %b want 0", bus.mat_valid); end
        n_checks++; if (bus.elem_cnt !== 5'd0) begin n_fail++; $display("FAIL rst_elem_cnt: got %0d want 0", bus.elem_cnt); end
        @(negedge clk) rst_n = 1'b1;
        step();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_identity();
        logic mv_early;
        for (int e = 0; e < 3; e++) begin
            bus.in_data = elem_val(0, e); bus.in_valid = 1'b1; step();
        end
        n_checks++; if (bus.elem_cnt !== 5'd3) begin n_fail++; $display("FAIL id_cnt3: got %0d want 3", bus.elem_cnt); end
        for (int e = 3; e < 50; e++) begin
            bus.in_data = elem_val(0, e); bus.in_valid = 1'b1;
            if (e == 49) mv_early = bus.mat_valid;
            step();
        end
        bus.in_valid = 1'b0;
        n_checks++; if (mv_early !== 1'b0) begin n_fail++; $display("FAIL id_mv_early: got %b want 0", mv_early); end
        n_checks++; if (bus.mat_valid !== 1'b1) begin n_fail++; $display("FAIL id_mat_valid: got %b want 1", bus.mat_valid); end
        n_checks++; if (bus.A[7:0] !== 8'd1) begin n_fail++; $display("FAIL id_a0: got %h want 01", bus.A[7:0]); end
        n_checks++; if (bus.A[199:192] !== 8'd25) begin n_fail++; $display("FAIL id_a24: got %h want 19", bus.A[199:192]); end
        n_checks++; if (bus.B[7:0] !== 8'd1) begin n_fail++; $display("FAIL id_b0: got %h want 01", bus.B[7:0]); end
        n_checks++; if (bus.B[15:8] !== 8'd0) begin n_fail++; $display("FAIL id_b1: got %h want 00", bus.B[15:8]); end
        n_checks++; if (bus.A !== exp_mat(0, 0)) begin n_fail++; $display("FAIL id_a_full: got %h want %h", bus.A, exp_mat(0, 0)); end
        n_checks++; if (bus.B !== exp_mat(0, 1)) begin n_fail++; $display("FAIL id_b_full: got %h want %h", bus.B, exp_mat(0, 1)); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL id_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (bus.elem_cnt !== 5'd0) begin n_fail++; $display("FAIL id_cnt_hold: got %0d want 0", bus.elem_cnt); end
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        bus.in_valid = 1'b1; bus.in_data = 8'h7F; bus.mat_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.in_ready !== 1'b0 || bus.mat_valid !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
        n_checks++; if (bus.A !== exp_mat(0, 0)) begin n_fail++; $display("FAIL hold_a: got %h want %h", bus.A, exp_mat(0, 0)); end
        n_checks++; if (bus.B !== exp_mat(0, 1)) begin n_fail++; $display("FAIL hold_b: got %h want %h", bus.B, exp_mat(0, 1)); end
        bus.mat_ready = 1'b1;
        step();
        bus.mat_ready = 1'b0; bus.in_valid = 1'b0;
        n_checks++; if (bus.mat_valid !== 1'b0) begin n_fail++; $display("FAIL hold_rel_mv: got %b want 0", bus.mat_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_rel_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.elem_cnt !== 5'd0) begin n_fail++; $display("FAIL hold_rel_cnt: got %0d want 0", bus.elem_cnt); end
    endtask

    task automatic test_bubbles();
        for (int e = 0; e < 50; e++) begin
            bus.in_data = elem_val(0, e); bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0; bus.in_data = 8'hEE; bus.mat_ready = (e == 5);
            step();
            bus.mat_ready = 1'b0;
            if (e == 12) begin
                n_checks++; if (bus.elem_cnt !== 5'd13) begin n_fail++; $display("FAIL bub_cnt_a: got %0d want 13", bus.elem_cnt); end
            end
            if (e == 30) begin
                n_checks++; if (bus.elem_cnt !== 5'd6) begin n_fail++; $display("FAIL bub_cnt_b: got %0d want 6", bus.elem_cnt); end
            end
        end
        n_checks++; if (bus.mat_valid !== 1'b1) begin n_fail++; $display("FAIL bub_mat_valid: got %b want 1", bus.mat_valid); end
        n_checks++; if (bus.A !== exp_mat(0, 0)) begin n_fail++; $display("FAIL bub_a: got %h want %h", bus.A, exp_mat(0, 0)); end
        n_checks++; if (bus.B !== exp_mat(0, 1)) begin n_fail++; $display("FAIL bub_b: got %h want %h", bus.B, exp_mat(0, 1)); end
    endtask

    task automatic test_abort();
        logic mv_early;
        for (int e = 0; e < 30; e++) begin
            bus.in_data = elem_val(0, e); bus.in_valid = 1'b1; step();
        end
        n_checks++; if (bus.elem_cnt !== 5'd5) begin n_fail++; $display("FAIL ab_cnt_pre: got %0d want 5", bus.elem_cnt); end
        bus.abort = 1'b1; bus.in_data = 8'h55; bus.mat_ready = 1'b1;
        step();
        bus.abort = 1'b0; bus.in_valid = 1'b0; bus.mat_ready = 1'b0;
        n_checks++; if (bus.elem_cnt !== 5'd0) begin n_fail++; $display("FAIL ab_cnt: got %0d want 0", bus.elem_cnt); end
        n_checks++; if (bus.A !== 200'd0) begin n_fail++; $display("FAIL ab_a: got %h want 0", bus.A); end
        n_checks++; if (bus.B !== 200'd0) begin n_fail++; $display("FAIL ab_b: got %h want 0", bus.B); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ab_ready: got %b want 1", bus.in_ready); end
        load_all(2, mv_early);
        n_checks++; if (mv_early !== 1'b0) begin n_fail++; $display("FAIL ab_mv_early: got %b want 0", mv_early); end
        n_checks++; if (bus.mat_valid !== 1'b1) begin n_fail++; $display("FAIL ab_mat_valid: got %b want 1", bus.mat_valid); end
        n_checks++; if (bus.A !== exp_mat(2, 0)) begin n_fail++; $display("FAIL ab_reload_a: got %h want %h", bus.A, exp_mat(2, 0)); end
        n_checks++; if (bus.B !== exp_mat(2, 1)) begin n_fail++; $display("FAIL ab_reload_b: got %h want %h", bus.B, exp_mat(2, 1)); end
    endtask

    task automatic test_all_min();
        logic mv_early;
        load_all(1, mv_early);
        n_checks++; if (bus.A !== {25{8'h80}}) begin n_fail++; $display("FAIL min_a: got %h want all 80", bus.A); end
        n_checks++; if (bus.B !== {25{8'h80}}) begin n_fail++; $display("FAIL min_b: got %h want all 80", bus.B); end
        n_checks++; if (bus.mat_valid !== 1'b1) begin n_fail++; $display("FAIL min_mat_valid: got %b want 1", bus.mat_valid); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.mat_valid !== 1'b0) begin n_fail++; $display("FAIL ar_mat_valid: got %b want 0", bus.mat_valid); end
        n_checks++; if (bus.A !== 200'd0) begin n_fail++; $display("FAIL ar_a: got %h want 0", bus.A); end
        n_checks++; if (bus.B !== 200'd0) begin n_fail++; $display("FAIL ar_b: got %h want 0", bus.B); end
        @(negedge clk) rst_n = 1'b1;
        step();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.elem_cnt !== 5'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", bus.elem_cnt); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_identity();
        test_hold();
        test_bubbles();
        release_hold();
        test_abort();
        release_hold();
        test_all_min();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
